// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle main controller for the MIPS core.
// Decodes the fetched instruction and walks it through FETCH/DCD/EXE/MEM/WB
// states. The PC is written exactly once per instruction, in its final state.
// An interrupt is taken after an instruction's final state completes.
module mc_ctrl #(
    parameter int INT_EN = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        int_req,
    output logic        PCWr,
    output logic [2:0]  nPC_sel,
    output logic        j_sel,
    output logic        jalr_en,
    output logic        IRWr,
    output logic        RegWr,
    output logic [1:0]  RegDst,
    output logic [1:0]  WbSel,
    output logic        ALUSrc,
    output logic        ExtOp,
    output logic [2:0]  ALUOp,
    output logic        MemWr,
    output logic        CP0Wr,
    output logic        EPCWr,
    output logic        EXLSet,
    output logic        EXLClr,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        FETCH = 4'd0,
        DCD   = 4'd1,
        EXE   = 4'd2,
        MADR  = 4'd3,
        MRD   = 4'd4,
        LWB   = 4'd5,
        SW    = 4'd6,
        ALUWB = 4'd7,
        BR    = 4'd8,
        JMP   = 4'd9,
        ERET  = 4'd10,
        INT   = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;
    state_t final_next;

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] cop_rs;
    logic       unused_instr_bits;

    logic is_rtype, is_addu, is_subu, is_slt, is_jr, is_jalr;
    logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic is_cop0, is_mfc0, is_mtc0, is_eret;
    logic take_int;
    logic [2:0] alu_op_dec;
    logic       alu_src_dec;

    assign opcode            = instr[31:26];
    assign funct             = instr[5:0];
    assign cop_rs            = instr[25:21];
    assign unused_instr_bits = ^instr[20:6];

    assign is_rtype = (opcode == 6'b000000);
    assign is_addu  = is_rtype && (funct == 6'b100001);
    assign is_subu  = is_rtype && (funct == 6'b100011);
    assign is_slt   = is_rtype && (funct == 6'b101010);
    assign is_jr    = is_rtype && (funct == 6'b001000);
    assign is_jalr  = is_rtype && (funct == 6'b001001);
    assign is_ori   = (opcode == 6'b001101);
    assign is_lui   = (opcode == 6'b001111);
    assign is_lw    = (opcode == 6'b100011);
    assign is_sw    = (opcode == 6'b101011);
    assign is_beq   = (opcode == 6'b000100);
    assign is_j     = (opcode == 6'b000010);
    assign is_jal   = (opcode == 6'b000011);
    assign is_cop0  = (opcode == 6'b010000);
    assign is_mfc0  = is_cop0 && (cop_rs == 5'b00000);
    assign is_mtc0  = is_cop0 && (cop_rs == 5'b00100);
    assign is_eret  = is_cop0 && instr[25] && (funct == 6'b011000);

    // An interrupt only diverts the flow once the current instruction is done.
    assign take_int   = (INT_EN != 0) && int_req;
    assign final_next = take_int ? INT : FETCH;
    assign state      = state_q;

    // ALU operation and operand source for the register/immediate ALU instructions.
    always_comb begin
        alu_op_dec  = 3'b000;
        alu_src_dec = 1'b0;
        if (is_subu) begin
            alu_op_dec = 3'b001;
        end else if (is_slt) begin
            alu_op_dec = 3'b011;
        end else if (is_ori) begin
            alu_op_dec  = 3'b010;
            alu_src_dec = 1'b1;
        end else if (is_lui) begin
            alu_op_dec  = 3'b100;
            alu_src_dec = 1'b1;
        end
    end

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and per-state control outputs.
    always_comb begin
        state_d = state_q;
        PCWr    = 1'b0;
        nPC_sel = 3'b000;
        j_sel   = 1'b0;
        jalr_en = 1'b0;
        IRWr    = 1'b0;
        RegWr   = 1'b0;
        RegDst  = 2'b00;
        WbSel   = 2'b00;
        ALUSrc  = 1'b0;
        ExtOp   = 1'b0;
        ALUOp   = 3'b000;
        MemWr   = 1'b0;
        CP0Wr   = 1'b0;
        EPCWr   = 1'b0;
        EXLSet  = 1'b0;
        EXLClr  = 1'b0;
        case (state_q)
            FETCH: begin
                IRWr    = 1'b1;
                state_d = DCD;
            end
            DCD: begin
                if (is_lw || is_sw)     state_d = MADR;
                else if (is_beq)        state_d = BR;
                else if (is_j || is_jal) state_d = JMP;
                else if (is_eret)       state_d = ERET;
                else                    state_d = EXE;
            end
            EXE: begin
                ALUSrc  = alu_src_dec;
                ALUOp   = alu_op_dec;
                state_d = ALUWB;
            end
            ALUWB: begin
                ALUSrc  = alu_src_dec;
                ALUOp   = alu_op_dec;
                PCWr    = 1'b1;
                state_d = final_next;
                if (is_jr) begin
                    nPC_sel = 3'b011;
                end else if (is_jalr) begin
                    RegWr   = 1'b1;
                    jalr_en = 1'b1;
                    RegDst  = 2'b01;
                    WbSel   = 2'b10;
                end else if (is_mfc0) begin
                    RegWr = 1'b1;
                    WbSel = 2'b11;
                end else if (is_mtc0) begin
                    CP0Wr = 1'b1;
                end else if (is_addu || is_subu || is_slt) begin
                    RegWr  = 1'b1;
                    RegDst = 2'b01;
                end else if (is_ori || is_lui) begin
                    RegWr = 1'b1;
                end
            end
            MADR: begin
                ALUSrc  = 1'b1;
                ExtOp   = 1'b1;
                state_d = is_sw ? SW : MRD;
            end
            MRD: begin
                state_d = LWB;
            end
            LWB: begin
                RegWr   = 1'b1;
                WbSel   = 2'b01;
                PCWr    = 1'b1;
                state_d = final_next;
            end
            SW: begin
                MemWr   = 1'b1;
                PCWr    = 1'b1;
                state_d = final_next;
            end
            BR: begin
                ALUOp   = 3'b001;
                PCWr    = 1'b1;
                nPC_sel = zero ? 3'b001 : 3'b000;
                state_d = final_next;
            end
            JMP: begin
                j_sel   = 1'b1;
                PCWr    = 1'b1;
                state_d = final_next;
                if (is_jal) begin
                    RegWr  = 1'b1;
                    RegDst = 2'b10;
                    WbSel  = 2'b10;
                end
            end
            ERET: begin
                nPC_sel = 3'b101;
                EXLClr  = 1'b1;
                PCWr    = 1'b1;
                state_d = FETCH;
            end
            INT: begin
                nPC_sel = 3'b100;
                EPCWr   = 1'b1;
                EXLSet  = 1'b1;
                PCWr    = 1'b1;
                state_d = FETCH;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

endmodule
